// File: rtl/invader_march_controller.sv
// Space-invader formation march: scans the alive mask once per frame, paces steps
// by survivor count, marches/drops the formation and flags invasion or wipe-out.
module invader_march_controller #(
  parameter int START_X   = 64,
  parameter int START_Y   = 32,
  parameter int STEP_H    = 4,
  parameter int STEP_V    = 16,
  parameter int COL_PITCH = 32,
  parameter int ROW_PITCH = 32,
  parameter int X_MIN     = 16,
  parameter int X_MAX     = 624,
  parameter int Y_LIMIT   = 416
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame,
  input  logic        enable,
  input  logic        restart,
  input  logic [54:0] invaders,
  output logic [9:0]  invaders_x,
  output logic [9:0]  invaders_y,
  output logic        dir,
  output logic        step_pulse,
  output logic        anim_frame,
  output logic        reached_bottom,
  output logic        all_clear
);

  typedef enum logic [2:0] {IDLE, WAIT, SCAN, MOVE, DONE} state_t;

  state_t      state;
  logic [3:0]  scan_col, leftcol, rightcol;
  logic        found;
  logic [5:0]  alive_acc, fcnt;

  logic [10:0] row_bits [5];
  logic [4:0]  col_bits;
  logic [2:0]  col_cnt;
  logic        col_any;
  logic [5:0]  alive_next;
  logic [3:0]  leftcol_next, rightcol_next;
  logic [10:0] left_edge, right_edge;
  logic [9:0]  drop_y;
  logic        at_edge, bottom;

  // One column of the mask per SCAN cycle, read live so mid-scan edits are seen.
  always_comb begin
    col_cnt = '0;
    for (int r = 0; r < 5; r++) begin
      row_bits[r] = invaders[r*11 +: 11];
      col_bits[r] = row_bits[r][scan_col];
      col_cnt     = col_cnt + {2'b00, col_bits[r]};
    end
    col_any       = |col_bits;
    alive_next    = alive_acc + {3'b000, col_cnt};
    leftcol_next  = (col_any && !found) ? scan_col : leftcol;
    rightcol_next = col_any ? scan_col : rightcol;
  end

  always_comb begin
    left_edge  = {1'b0, invaders_x} + 11'(leftcol) * 11'(COL_PITCH);
    right_edge = {1'b0, invaders_x} + (11'(rightcol) + 11'd1) * 11'(COL_PITCH);
    drop_y     = invaders_y + 10'(STEP_V);
    at_edge    = dir ? (left_edge < 11'(X_MIN + STEP_H))
                     : ((right_edge + 11'(STEP_H)) > 11'(X_MAX));
    bottom     = ({1'b0, drop_y} + 11'(5 * ROW_PITCH)) >= 11'(Y_LIMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      invaders_x     <= 10'(START_X);
      invaders_y     <= 10'(START_Y);
      dir            <= 1'b0;
      fcnt           <= '0;
      step_pulse     <= 1'b0;
      anim_frame     <= 1'b0;
      reached_bottom <= 1'b0;
      all_clear      <= 1'b0;
      scan_col       <= '0;
      leftcol        <= '0;
      rightcol       <= '0;
      found          <= 1'b0;
      alive_acc      <= '0;
    end else begin
      step_pulse <= 1'b0;
      if (restart) begin
        state          <= IDLE;
        invaders_x     <= 10'(START_X);
        invaders_y     <= 10'(START_Y);
        dir            <= 1'b0;
        fcnt           <= '0;
        anim_frame     <= 1'b0;
        reached_bottom <= 1'b0;
        all_clear      <= 1'b0;
      end else begin
        case (state)
          IDLE: if (enable) state <= WAIT;
          WAIT: if (enable && frame) begin
            state     <= SCAN;
            scan_col  <= '0;
            leftcol   <= '0;
            rightcol  <= '0;
            found     <= 1'b0;
            alive_acc <= '0;
          end
          SCAN: begin
            alive_acc <= alive_next;
            found     <= found | col_any;
            leftcol   <= leftcol_next;
            rightcol  <= rightcol_next;
            scan_col  <= scan_col + 4'd1;
            if (scan_col == 4'd10) begin
              // Pacing compares the pre-increment count: 55 alive -> every 14th frame.
              if (alive_next == 6'd0) begin
                all_clear <= 1'b1;
                state     <= DONE;
              end else if (fcnt >= (alive_next >> 2)) begin
                fcnt  <= '0;
                state <= MOVE;
              end else begin
                fcnt  <= fcnt + 6'd1;
                state <= WAIT;
              end
            end
          end
          MOVE: begin
            step_pulse <= 1'b1;
            anim_frame <= ~anim_frame;
            state      <= WAIT;
            if (at_edge) begin
              invaders_y <= drop_y;
              dir        <= ~dir;
              if (bottom) begin
                reached_bottom <= 1'b1;
                state          <= DONE;
              end
            end else if (dir) begin
              invaders_x <= invaders_x - 10'(STEP_H);
            end else begin
              invaders_x <= invaders_x + 10'(STEP_H);
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/invader_march_controller.md
INVADER_MARCH_CONTROLLER -- requirements
Module: invader_march_controller

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- START_X, 64, formation origin x after reset/restart
- START_Y, 32, formation origin y after reset/restart
- STEP_H, 4, horizontal pixels per step
- STEP_V, 16, vertical pixels per drop
- COL_PITCH, 32, column spacing in pixels
- ROW_PITCH, 32, row spacing in pixels
- X_MIN, 16, leftmost legal pixel
- X_MAX, 624, rightmost legal pixel, exclusive
- Y_LIMIT, 416, invasion line
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, reset, asynchronous, active-high
- frame, in, 1, one-cycle pulse per video frame
- enable, in, 1, game running; low freezes the march
- restart, in, 1, synchronous re-init pulse
- invaders, in, 55, alive mask; index = row*11 + col, rows 0-4, cols 0-10
- invaders_x, out, 10, formation origin x
- invaders_y, out, 10, formation origin y
- dir, out, 1, 0 = right, 1 = left
- step_pulse, out, 1, one-cycle pulse on every move or drop
- anim_frame, out, 1, toggles on every step_pulse
- reached_bottom, out, 1, sticky: formation hit Y_LIMIT
- all_clear, out, 1, sticky: mask became zero

Function
REQ-003 The FSM SHALL have states IDLE, WAIT, SCAN, MOVE and DONE.
REQ-004 IDLE SHALL go to WAIT when enable=1.
REQ-005 In WAIT with enable=1, a frame pulse SHALL go to SCAN. With enable=0, frame pulses SHALL be ignored and all state SHALL hold.
REQ-006 SCAN SHALL run exactly 11 cycles, column 0 to 10, one column per cycle, and SHALL compute:
- leftcol: lowest column with any alive bit
- rightcol: highest column with any alive bit
- alive_count: 6-bit popcount of the mask
REQ-007 When SCAN finds alive_count=0, the block SHALL set all_clear=1 and go to DONE with no move.
REQ-008 Otherwise the frame counter fcnt SHALL increment. When fcnt >= (alive_count>>2), the block SHALL clear fcnt and go to MOVE; otherwise it SHALL return to WAIT. With 55 alive this gives one step every 14 frames; with 1 alive, one step every frame.
REQ-009 Edges SHALL be computed with 11-bit unsigned arithmetic:
- left edge L = invaders_x + leftcol*COL_PITCH
- right edge R = invaders_x + (rightcol+1)*COL_PITCH
REQ-010 MOVE with dir=0 SHALL behave as follows:
- R+STEP_H > X_MAX: drop, invaders_y += STEP_V, dir becomes 1, x unchanged
- else: invaders_x += STEP_H
REQ-011 MOVE with dir=1 SHALL behave as follows:
- L < X_MIN+STEP_H: drop, invaders_y += STEP_V, dir becomes 0, x unchanged
- else: invaders_x -= STEP_H
REQ-012 MOVE SHALL last one cycle and assert step_pulse in the cycle after MOVE, registered. anim_frame SHALL toggle in that same cycle.
REQ-013 After a drop, if new invaders_y + 5*ROW_PITCH >= Y_LIMIT, the block SHALL set reached_bottom=1 and go to DONE; otherwise it SHALL go to WAIT.
REQ-014 DONE SHALL hold all outputs until restart or rst.
REQ-015 restart SHALL take priority over every state and over a simultaneous frame pulse. It SHALL load START_X/START_Y, clear dir, fcnt, anim_frame and the sticky flags, and go to IDLE next cycle.
REQ-016 Mask changes during SCAN SHALL be sampled per column as scanned; no re-scan SHALL occur. A frame pulse arriving in SCAN or MOVE SHALL be dropped.
REQ-017 Position outputs SHALL change only in the cycle after MOVE and SHALL never go below X_MIN or beyond X_MAX at the alive edges.

Reset
REQ-018 While rst=1, the block SHALL force: state IDLE, invaders_x=START_X, invaders_y=START_Y, dir=0, fcnt=0, step_pulse=0, anim_frame=0, reached_bottom=0, all_clear=0.
REQ-019 Reset assertion mid-SCAN or mid-MOVE SHALL abort immediately with no partial position update.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Full mask, enable=1, 14 frame pulses -> exactly one step_pulse; invaders_x 64->68; anim_frame=1.
- Mask with only col 10 alive (bit 10 set), x advanced until R=624-STEP_H+1 -> next step drops: y +16, dir=1, x unchanged.
- dir=1, only col 0 alive, invaders_x=19 -> drop instead of move; dir=0.
- invaders_y=272 and a drop occurs -> y=288, 288+160>=416, reached_bottom=1, DONE; later frames cause no change.
- Mask cleared to 0 -> at the next frame, after SCAN, all_clear=1 and no step_pulse.
- Assert restart simultaneous with a frame in WAIT, and separately rst mid-SCAN -> x=64, y=32, dir=0, flags 0, state IDLE.
